// File: rtl/spi_fb_ctrl.sv
// spi_fb_ctrl: SPI-slave command decoder driving framebuffer pixel writes
// and the video-enable / background-colour configuration registers.
//
// Ports:
//   clk_i, rst_i           pixel clock, synchronous active-high reset
//   io_SPISignals_*        raw SPI pins (mode 0, SS active-low, MSB first)
//   fb_wr_valid_o/ready_i  framebuffer write handshake
//   fb_wr_addr_o/data_o    pixel address and value
//   cfg_video_en_o         video generator enable
//   cfg_bg_o               background colour {R,G,B}
//   ovf_o                  sticky pixel-dropped flag
//   frame_cnt_o            completed-frame counter (SPI_FRAME_CNT_EN only)
//
// Build option: define SPI_FRAME_CNT_EN to add frame_cnt_o.
module spi_fb_ctrl #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              io_SPISignals_SCLK,
    input  logic              io_SPISignals_SS,
    input  logic              io_SPISignals_MOSI,
    output logic              fb_wr_valid_o,
    input  logic              fb_wr_ready_i,
    output logic [ADDR_W-1:0] fb_wr_addr_o,
    output logic [DATA_W-1:0] fb_wr_data_o,
    output logic              cfg_video_en_o,
    output logic [23:0]       cfg_bg_o,
    output logic              ovf_o
`ifdef SPI_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt_o
`endif
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CMD    = 4'd1;
    localparam logic [3:0] S_ADDRHI = 4'd2;
    localparam logic [3:0] S_ADDRLO = 4'd3;
    localparam logic [3:0] S_PIXELS = 4'd4;
    localparam logic [3:0] S_BGR    = 4'd5;
    localparam logic [3:0] S_BGG    = 4'd6;
    localparam logic [3:0] S_BGB    = 4'd7;
    localparam logic [3:0] S_EN     = 4'd8;
    localparam logic [3:0] S_IGNORE = 4'd9;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic sclk_s, ss_s, mosi_s;
    logic sclk_prev_q, ss_prev_q;
    logic sclk_rise, ss_fall, xfer;

    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        byte_q, byte_d;
    logic              byte_vld_q, byte_vld_d;
    logic [3:0]        state_q, state_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              en_q, en_d;
    logic [7:0]        bg_r_q, bg_r_d, bg_g_q, bg_g_d;
    logic [23:0]       bg_q, bg_d;
    logic              ovf_q, ovf_d;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;
    assign xfer      = valid_q & fb_wr_ready_i;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        state_d    = state_q;
        addr_hi_d  = addr_hi_q;
        ptr_d      = ptr_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        en_d       = en_q;
        bg_r_d     = bg_r_q;
        bg_g_d     = bg_g_q;
        bg_d       = bg_q;
        ovf_d      = ovf_q;

        // Byte assembly; SS high discards any partial byte.
        if (ss_s) begin
            bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            shift_d   = {shift_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_vld_d = 1'b1;
                byte_d     = shift_d;
            end
        end

        // Output buffer drains on handshake; a new load below re-arms it.
        if (xfer) begin
            valid_d = 1'b0;
        end

        if (ss_s) begin
            state_d = S_IDLE;
        end else if (ss_fall) begin
            state_d = S_CMD;
        end else if (byte_vld_q) begin
            case (state_q)
                S_CMD: begin
                    case (byte_q)
                        8'h01: state_d = S_ADDRHI;
                        8'h02: state_d = S_BGR;
                        8'h03: state_d = S_EN;
                        8'h04: begin
                            ovf_d   = 1'b0;
                            state_d = S_IGNORE;
                        end
                        default: state_d = S_IGNORE;
                    endcase
                end
                S_ADDRHI: begin
                    addr_hi_d = byte_q;
                    state_d   = S_ADDRLO;
                end
                S_ADDRLO: begin
                    ptr_d   = ADDR_W'({addr_hi_q, byte_q});
                    state_d = S_PIXELS;
                end
                S_PIXELS: begin
                    if (!valid_q || xfer) begin
                        valid_d = 1'b1;
                        addr_d  = ptr_q;
                        data_d  = DATA_W'(byte_q);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    // Advance even on a drop so later pixels stay aligned.
                    ptr_d = ptr_q + 1'b1;
                end
                S_BGR: begin
                    bg_r_d  = byte_q;
                    state_d = S_BGG;
                end
                S_BGG: begin
                    bg_g_d  = byte_q;
                    state_d = S_BGB;
                end
                S_BGB: begin
                    bg_d    = {bg_r_q, bg_g_q, byte_q};
                    state_d = S_IGNORE;
                end
                S_EN: begin
                    en_d    = byte_q[0];
                    state_d = S_IGNORE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            byte_q      <= 8'd0;
            byte_vld_q  <= 1'b0;
            state_q     <= S_IDLE;
            addr_hi_q   <= 8'd0;
            ptr_q       <= '0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            en_q        <= 1'b0;
            bg_r_q      <= 8'd0;
            bg_g_q      <= 8'd0;
            bg_q        <= 24'd0;
            ovf_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], io_SPISignals_SCLK};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], io_SPISignals_SS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], io_SPISignals_MOSI};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            byte_vld_q  <= byte_vld_d;
            state_q     <= state_d;
            addr_hi_q   <= addr_hi_d;
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            en_q        <= en_d;
            bg_r_q      <= bg_r_d;
            bg_g_q      <= bg_g_d;
            bg_q        <= bg_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef SPI_FRAME_CNT_EN
    logic        ss_rise;
    logic        got_byte_q, got_byte_d;
    logic [15:0] fcnt_q, fcnt_d;

    assign ss_rise = ss_s & ~ss_prev_q;

    // Only frames that carried at least one whole byte are counted.
    always_comb begin
        got_byte_d = got_byte_q | byte_vld_q;
        fcnt_d     = fcnt_q;
        if (ss_rise) begin
            if (got_byte_q || byte_vld_q) begin
                fcnt_d = fcnt_q + 16'd1;
            end
            got_byte_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            got_byte_q <= 1'b0;
            fcnt_q     <= 16'd0;
        end else begin
            got_byte_q <= got_byte_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign frame_cnt_o = fcnt_q;
`endif

    assign fb_wr_valid_o  = valid_q;
    assign fb_wr_addr_o   = addr_q;
    assign fb_wr_data_o   = data_q;
    assign cfg_video_en_o = en_q;
    assign cfg_bg_o       = bg_q;
    assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_spi_fb_ctrl.sv
// tb_spi_fb_ctrl: directed self-checking bench for spi_fb_ctrl.
// Drives SPI frames bit-by-bit and logs framebuffer writes.
module tb_spi_fb_ctrl;

    localparam int AW = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic        ready = 1'b1;
    logic        valid;
    logic [AW-1:0] addr;
    logic [7:0]  data;
    logic        en;
    logic [23:0] bg;
    logic        ovf;
`ifdef SPI_FRAME_CNT_EN
    logic [15:0] fcnt;
`endif

    int ncmp = 0;
    int nerr = 0;
    logic [AW+7:0] wq[$];

    always #5 clk = ~clk;

    spi_fb_ctrl #(.ADDR_W(AW), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .io_SPISignals_SCLK (sclk),
        .io_SPISignals_SS   (ss),
        .io_SPISignals_MOSI (mosi),
        .fb_wr_valid_o      (valid),
        .fb_wr_ready_i      (ready),
        .fb_wr_addr_o       (addr),
        .fb_wr_data_o       (data),
        .cfg_video_en_o     (en),
        .cfg_bg_o           (bg),
        .ovf_o              (ovf)
`ifdef SPI_FRAME_CNT_EN
        ,
        .frame_cnt_o        (fcnt)
`endif
    );

    // ready only changes just after posedge, so negedge sees the
    // value that the next posedge will use.
    always @(negedge clk) begin
        if (valid && ready && !rst) wq.push_back({addr, data});
    end

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
    endtask

    task automatic ss_lo();
        ss = 1'b0;
        #40;
    endtask

    task automatic ss_hi();
        #40 ss = 1'b1;
        #200;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #2 ready = r;
    endtask

    task automatic check_writes(input string nm, input int n,
                                input logic [AW+7:0] exp[3]);
        ncmp++;
        if (wq.size() != n) begin
            nerr++;
            $display("FAIL %s count: got %0d want %0d", nm, wq.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                ncmp++;
                if (wq[i] !== exp[i]) begin
                    nerr++;
                    $display("FAIL %s wr%0d: got %h want %h",
                             nm, i, wq[i], exp[i]);
                end
            end
        end
        wq.delete();
    endtask

    task automatic test_reset();
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #20;
        ncmp++;
        if ({valid, addr, data, en, bg, ovf} !== '0) begin
            nerr++;
            $display("FAIL reset: got v=%b a=%h d=%h en=%b bg=%h ovf=%b want 0",
                     valid, addr, data, en, bg, ovf);
        end
    endtask

    task automatic test_pixels();
        logic [AW+7:0] e[3];
        e = '{{14'h0010, 8'hAA}, {14'h0011, 8'hBB}, {14'h0012, 8'hCC}};
        ss_lo();
        spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h10);
        spi_byte(8'hAA); spi_byte(8'hBB); spi_byte(8'hCC);
        ss_hi();
        check_writes("pixels", 3, e);
        ncmp++;
        if (ovf !== 1'b0) begin
            nerr++;
            $display("FAIL pixels_ovf: got %b want 0", ovf);
        end
    endtask

    task automatic test_wrap();
        logic [AW+7:0] e[3];
        e = '{{14'h3FFF, 8'h11}, {14'h0000, 8'h22}, '0};
        ss_lo();
        spi_byte(8'h01); spi_byte(8'h3F); spi_byte(8'hFF);
        spi_byte(8'h11); spi_byte(8'h22);
        ss_hi();
        check_writes("wrap", 2, e);
        e = '{{14'h3F80, 8'h33}, '0, '0};
        ss_lo();
        spi_byte(8'h01); spi_byte(8'hFF); spi_byte(8'h80);
        spi_byte(8'h33);
        ss_hi();
        check_writes("upper_bits", 1, e);
    endtask

    task automatic test_cfg();
        ncmp++;
        if (en !== 1'b0) begin
            nerr++;
            $display("FAIL en_before: got %b want 0", en);
        end
        ss_lo();
        spi_byte(8'h02); spi_byte(8'h12); spi_byte(8'h34);
        #200;
        ncmp++;
        if (bg !== 24'h0) begin
            nerr++;
            $display("FAIL bg_partial: got %h want 000000", bg);
        end
        spi_byte(8'h56);
        ss_hi();
        ncmp++;
        if (bg !== 24'h123456) begin
            nerr++;
            $display("FAIL bg: got %h want 123456", bg);
        end
        ss_lo();
        spi_byte(8'h03); spi_byte(8'h01);
        ss_hi();
        ncmp++;
        if (en !== 1'b1) begin
            nerr++;
            $display("FAIL en: got %b want 1", en);
        end
    endtask

    task automatic test_stall();
        logic [AW+7:0] e[3];
        e = '{{14'h0000, 8'hA1}, '0, '0};
        set_ready(1'b0);
        ss_lo();
        spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h00);
        spi_byte(8'hA1);
        #100;
        ncmp++;
        if ({valid, addr, data} !== {1'b1, 14'h0000, 8'hA1}) begin
            nerr++;
            $display("FAIL stall_load: got v=%b %h/%h want 1 0000/a1",
                     valid, addr, data);
        end
        spi_byte(8'hA2); spi_byte(8'hA3);
        ss_hi();
        ncmp++;
        if ({valid, addr, data, ovf} !== {1'b1, 14'h0000, 8'hA1, 1'b1}) begin
            nerr++;
            $display("FAIL stall_hold: got v=%b %h/%h ovf=%b want 1 0000/a1 1",
                     valid, addr, data, ovf);
        end
        set_ready(1'b1);
        #100;
        check_writes("stall", 1, e);
        ncmp++;
        if (valid !== 1'b0) begin
            nerr++;
            $display("FAIL stall_drain: got valid=%b want 0", valid);
        end
        ss_lo();
        spi_byte(8'h04);
        ss_hi();
        ncmp++;
        if (ovf !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_clear: got %b want 0", ovf);
        end
    endtask

    task automatic test_glitch();
        logic [AW+7:0] e[3];
        e = '{{14'h0005, 8'h7E}, '0, '0};
        ss_lo();
        spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h20);
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1;
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
        ss_hi();
        ncmp++;
        if (wq.size() != 0) begin
            nerr++;
            $display("FAIL glitch_nowrite: got %0d writes want 0", wq.size());
        end
        wq.delete();
        ss_lo();
        spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h05);
        spi_byte(8'h7E);
        ss_hi();
        check_writes("glitch", 1, e);
    endtask

    task automatic test_reset_pending();
        set_ready(1'b0);
        ss_lo();
        spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h07);
        spi_byte(8'h99);
        ss_hi();
        ncmp++;
        if ({valid, addr, data} !== {1'b1, 14'h0007, 8'h99}) begin
            nerr++;
            $display("FAIL pend: got v=%b %h/%h want 1 0007/99",
                     valid, addr, data);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        ncmp++;
        if ({valid, addr, data, en, bg, ovf} !== '0) begin
            nerr++;
            $display("FAIL rst_pend: got v=%b a=%h d=%h en=%b bg=%h ovf=%b want 0",
                     valid, addr, data, en, bg, ovf);
        end
        set_ready(1'b1);
        #100;
        ncmp++;
        if (wq.size() != 0) begin
            nerr++;
            $display("FAIL rst_nowrite: got %0d writes want 0", wq.size());
        end
        wq.delete();
    endtask

`ifdef SPI_FRAME_CNT_EN
    task automatic test_frame_cnt();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #100;
        ss_lo();
        ss_hi();
        for (int i = 0; i < 3; i++) begin
            ss_lo();
            spi_byte(8'h03); spi_byte(8'h01);
            ss_hi();
        end
        ncmp++;
        if (fcnt !== 16'd3) begin
            nerr++;
            $display("FAIL frame_cnt: got %0d want 3", fcnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pixels();
        test_wrap();
        test_cfg();
        test_stall();
        test_glitch();
        test_reset_pending();
`ifdef SPI_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
